// File: rtl/control_unit_mc.sv
// Multi-cycle fetch/decode/execute control FSM for the 8-bit uC datapath, with a
// memory wait-state handshake, optional access timeout and optional HALT resume.
module control_unit_mc #(
  parameter bit          EXT_OPS      = 1'b1,
  parameter bit          HALT_RESUME  = 1'b0,
  parameter int unsigned WAIT_TIMEOUT = 0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Enter,
  input  logic       Aeq0,
  input  logic       Apos,
  input  logic [3:0] IR,
  input  logic       MemRdy,
  output logic       IRload,
  output logic       PCload,
  output logic       JMPmux,
  output logic       Meminst,
  output logic       MemReq,
  output logic       MemWr,
  output logic [1:0] Asel,
  output logic       Aload,
  output logic [1:0] AluOp,
  output logic       Halt,
  output logic       MemErr
);

  localparam int unsigned CNT_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

  localparam logic [3:0] OP_LOAD  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_IN    = 4'd4;
  localparam logic [3:0] OP_JZ    = 4'd5;
  localparam logic [3:0] OP_JPOS  = 4'd6;
  localparam logic [3:0] OP_HALT  = 4'd7;
  localparam logic [3:0] OP_AND   = 4'd8;
  localparam logic [3:0] OP_OR    = 4'd9;
  localparam logic [3:0] OP_JMP   = 4'd10;

  typedef enum logic [3:0] {
    S_START    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_OP   = 4'd3,
    S_IN_WAIT  = 4'd4,
    S_IN_REL   = 4'd5,
    S_BRANCH   = 4'd6,
    S_HALT     = 4'd7,
    S_HALT_REL = 4'd8
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [3:0]       op;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;
  logic             fault;
  logic             waiting;

  // Without the extended ISA the top opcode bit is treated as zero.
  assign op          = EXT_OPS ? IR : {1'b0, IR[2:0]};
  assign waiting     = MemReq && !MemRdy;
  assign timeout_hit = (WAIT_TIMEOUT > 0) && (wait_cnt == CNT_LAST);

  // Next state plus the handshake-qualified load strobes.
  always_comb begin
    state_next = state;
    fault      = 1'b0;
    IRload     = 1'b0;
    PCload     = 1'b0;
    Aload      = 1'b0;
    case (state)
      S_START: state_next = S_FETCH;
      S_FETCH: begin
        if (MemRdy) begin
          IRload     = 1'b1;
          PCload     = 1'b1;
          state_next = S_DECODE;
        end else if (timeout_hit) begin
          fault      = 1'b1;
          state_next = S_HALT;
        end
      end
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_OR: state_next = S_MEM_OP;
          OP_IN:                                            state_next = S_IN_WAIT;
          OP_JZ, OP_JPOS, OP_JMP:                           state_next = S_BRANCH;
          OP_HALT:                                          state_next = S_HALT;
          default:                                          state_next = S_FETCH;
        endcase
      end
      S_MEM_OP: begin
        if (MemRdy) begin
          Aload      = (op != OP_STORE);
          state_next = S_FETCH;
        end else if (timeout_hit) begin
          fault      = 1'b1;
          state_next = S_HALT;
        end
      end
      S_IN_WAIT: begin
        if (Enter) begin
          Aload      = 1'b1;
          state_next = S_IN_REL;
        end
      end
      S_IN_REL: begin
        if (!Enter) state_next = S_FETCH;
      end
      S_BRANCH: begin
        state_next = S_FETCH;
        case (op)
          OP_JZ:   PCload = Aeq0;
          OP_JPOS: PCload = Apos;
          OP_JMP:  PCload = 1'b1;
          default: PCload = 1'b0;
        endcase
      end
      S_HALT: begin
        if (HALT_RESUME && !MemErr && Enter) state_next = S_HALT_REL;
      end
      S_HALT_REL: begin
        if (!Enter) state_next = S_FETCH;
      end
      default: state_next = S_START;
    endcase
  end

  // State, wait counter, sticky fault and Moore outputs decoded from the next state.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= S_START;
      wait_cnt <= '0;
      MemErr   <= 1'b0;
      MemReq   <= 1'b0;
      Meminst  <= 1'b0;
      MemWr    <= 1'b0;
      JMPmux   <= 1'b0;
      Asel     <= 2'b00;
      AluOp    <= 2'b00;
      Halt     <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        wait_cnt <= '0;
      end else if (waiting && (WAIT_TIMEOUT > 0)) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (fault) MemErr <= 1'b1;
      MemReq  <= (state_next == S_FETCH) || (state_next == S_MEM_OP);
      Meminst <= (state_next == S_MEM_OP);
      MemWr   <= (state_next == S_MEM_OP) && (op == OP_STORE);
      JMPmux  <= (state_next == S_BRANCH);
      Halt    <= (state_next == S_HALT) || (state_next == S_HALT_REL);
      if ((state_next == S_MEM_OP) && (op == OP_LOAD)) begin
        Asel <= 2'b10;
      end else if (state_next == S_IN_WAIT) begin
        Asel <= 2'b01;
      end else begin
        Asel <= 2'b00;
      end
      if (state_next == S_MEM_OP) begin
        case (op)
          OP_SUB:  AluOp <= 2'b01;
          OP_AND:  AluOp <= 2'b10;
          OP_OR:   AluOp <= 2'b11;
          default: AluOp <= 2'b00;
        endcase
      end else begin
        AluOp <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_control_unit_mc.sv
// Directed bench for control_unit_mc: expected output vectors are queued per cycle
// and checked against the DUT on the falling edge.
module tb_control_unit_mc;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Enter;
  logic       Aeq0;
  logic       Apos;
  logic [3:0] IR;
  logic       MemRdy;
  logic       IRload, PCload, JMPmux, Meminst, MemReq, MemWr, Aload, Halt, MemErr;
  logic [1:0] Asel, AluOp;
  logic [12:0] obs;

  typedef struct {
    string       tag;
    logic [12:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [3:0] alu_ops [4] = '{4'd2, 4'd3, 4'd8, 4'd9};
  logic [1:0] alu_sel [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [3:0] br_op   [5] = '{4'd5, 4'd5, 4'd6, 4'd6, 4'd10};
  logic       br_aeq0 [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic       br_apos [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       br_pc   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  control_unit_mc #(
    .EXT_OPS(1'b1),
    .HALT_RESUME(1'b1),
    .WAIT_TIMEOUT(4)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Enter(Enter), .Aeq0(Aeq0), .Apos(Apos), .IR(IR),
    .MemRdy(MemRdy), .IRload(IRload), .PCload(PCload), .JMPmux(JMPmux),
    .Meminst(Meminst), .MemReq(MemReq), .MemWr(MemWr), .Asel(Asel), .Aload(Aload),
    .AluOp(AluOp), .Halt(Halt), .MemErr(MemErr)
  );

  always #5 Clk = ~Clk;

  assign obs = {IRload, PCload, JMPmux, Meminst, MemReq, MemWr, Asel, Aload, AluOp, Halt, MemErr};

  function automatic logic [12:0] ov(input logic irl, input logic pcl, input logic jm,
                                     input logic mi, input logic mr, input logic mw,
                                     input logic [1:0] as, input logic al,
                                     input logic [1:0] op, input logic h, input logic me);
    return {irl, pcl, jm, mi, mr, mw, as, al, op, h, me};
  endfunction

  task automatic push(input string tag, input logic [12:0] e);
    exp_t it;
    it.tag = tag;
    it.val = e;
    sb.push_back(it);
  endtask

  task automatic compare_head();
    exp_t it;
    it = sb.pop_front();
    n_cmp++;
    assert (obs === it.val) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", it.tag, obs, it.val);
    end
  endtask

  // One clock cycle: queue the expectation, check mid-cycle, step past the next rising edge.
  task automatic cyc(input string tag, input logic [12:0] e);
    push(tag, e);
    @(negedge Clk);
    compare_head();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_now(input string tag, input logic [12:0] e);
    push(tag, e);
    compare_head();
  endtask

  task automatic fetch_decode(input string tag, input logic [3:0] op);
    IR     = op;
    MemRdy = 1'b1;
    cyc({tag, "_fetch"}, ov(H, H, L, L, H, L, 2'b00, L, 2'b00, L, L));
    MemRdy = 1'b0;
    cyc({tag, "_decode"}, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    Reset  = 1'b0;
    Enter  = 1'b0;
    Aeq0   = 1'b0;
    Apos   = 1'b0;
    MemRdy = 1'b1;
    IR     = 4'd0;
    cyc("reset", '0);
    Reset = 1'b1;

    // LOAD with memory always ready
    cyc("t1_start", '0);
    fetch_decode("t1", 4'd0);
    MemRdy = 1'b1;
    cyc("t1_load_exec", ov(L, L, L, H, H, L, 2'b10, H, 2'b00, L, L));

    // STORE with three wait states; ready lands on the last legal wait cycle
    fetch_decode("t2", 4'd1);
    for (int i = 0; i < 3; i++) cyc("t2_store_wait", ov(L, L, L, H, H, H, 2'b00, L, 2'b00, L, L));
    MemRdy = 1'b1;
    cyc("t2_store_done", ov(L, L, L, H, H, H, 2'b00, L, 2'b00, L, L));
    MemRdy = 1'b0;
    cyc("t2_fetch_wait", ov(L, L, L, L, H, L, 2'b00, L, 2'b00, L, L));

    for (int i = 0; i < 4; i++) begin
      fetch_decode("alu", alu_ops[i]);
      MemRdy = 1'b1;
      cyc("alu_exec", ov(L, L, L, H, H, L, 2'b00, H, alu_sel[i], L, L));
    end

    fetch_decode("nop", 4'd12);
    cyc("nop_fetch", ov(L, L, L, L, H, L, 2'b00, L, 2'b00, L, L));

    for (int i = 0; i < 5; i++) begin
      fetch_decode("br", br_op[i]);
      Aeq0 = br_aeq0[i];
      Apos = br_apos[i];
      cyc("branch", ov(L, br_pc[i], H, L, L, L, 2'b00, L, 2'b00, L, L));
    end
    Aeq0 = 1'b0;
    Apos = 1'b0;

    // IN with Enter held: single A load
    fetch_decode("in", 4'd4);
    cyc("in_wait", ov(L, L, L, L, L, L, 2'b01, L, 2'b00, L, L));
    Enter = 1'b1;
    cyc("in_load", ov(L, L, L, L, L, L, 2'b01, H, 2'b00, L, L));
    for (int i = 0; i < 4; i++) cyc("in_held", '0);
    Enter = 1'b0;
    cyc("in_release", '0);
    cyc("in_fetch", ov(L, L, L, L, H, L, 2'b00, L, 2'b00, L, L));

    // HALT then resume on an Enter pulse
    fetch_decode("hr", 4'd7);
    cyc("halt", ov(L, L, L, L, L, L, 2'b00, L, 2'b00, H, L));
    Enter = 1'b1;
    cyc("halt_enter", ov(L, L, L, L, L, L, 2'b00, L, 2'b00, H, L));
    cyc("halt_rel_held", ov(L, L, L, L, L, L, 2'b00, L, 2'b00, H, L));
    Enter = 1'b0;
    cyc("halt_rel_exit", ov(L, L, L, L, L, L, 2'b00, L, 2'b00, H, L));

    // Fetch never completes: four wait cycles then fault
    for (int i = 0; i < 4; i++) cyc("to_wait", ov(L, L, L, L, H, L, 2'b00, L, 2'b00, L, L));
    cyc("to_fault", ov(L, L, L, L, L, L, 2'b00, L, 2'b00, H, H));
    Enter = 1'b1;
    cyc("to_enter_ign", ov(L, L, L, L, L, L, 2'b00, L, 2'b00, H, H));
    Enter = 1'b0;
    cyc("to_stay", ov(L, L, L, L, L, L, 2'b00, L, 2'b00, H, H));
    cyc("to_stay2", ov(L, L, L, L, L, L, 2'b00, L, 2'b00, H, H));
    Reset = 1'b0;
    #1;
    check_now("to_reset", '0);
    @(posedge Clk);
    #1;
    Reset = 1'b1;

    // Reset asserted in the middle of a memory access
    cyc("rs_start", '0);
    fetch_decode("rs", 4'd0);
    cyc("rs_memop", ov(L, L, L, H, H, L, 2'b10, L, 2'b00, L, L));
    #2;
    Reset = 1'b0;
    #1;
    check_now("rs_async", '0);
    @(posedge Clk);
    #1;
    cyc("rs_hold", '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
